// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron MAC sequencer and its datapath.
// Holds the sequencer state encoding and the coefficient-index geometry.
package neuron_pkg;

    localparam int NUM_COEFF = 20;
    localparam int SEL_W     = 5;

    localparam logic [SEL_W-1:0] OFFSET_SEL   = SEL_W'(NUM_COEFF);
    localparam logic [SEL_W-1:0] LAST_ACC_SEL = SEL_W'(NUM_COEFF - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ACCUM,
        OFFSET,
        DONE
    } state_t;

endpackage

// File: rtl/neuron_mac_unit.sv
// Signed multiply-accumulate datapath with offset add and final ResWidth conversion.
// Latency: product folds into acc each enabled edge; result registers on the offset edge.
// No backpressure: driven purely by the sequencer's clear/acc/offset strobes.
// Build option SATURATE_EN: clamp the final sum instead of wrapping it.
module neuron_mac_unit #(
    parameter int Width    = 4,
    parameter int AccWidth = 2*Width+5,
    parameter int ResWidth = 2*Width
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_clr,
    input  logic                       i_acc,
    input  logic                       i_offset,
    input  logic signed [Width-1:0]    i_coeff,
    input  logic signed [Width-1:0]    i_x,
    output logic signed [ResWidth-1:0] o_result
);

    logic signed [AccWidth-1:0]   r_acc;
    logic signed [ResWidth-1:0]   r_result;
    logic signed [2*Width-1:0]    w_prod;
    logic signed [AccWidth-1:0]   w_prod_ext;
    logic signed [AccWidth-1:0]   w_off_ext;
    logic signed [AccWidth-1:0]   w_sum;
    logic signed [ResWidth-1:0]   w_res;

    assign w_prod     = (2*Width)'(i_coeff) * (2*Width)'(i_x);
    assign w_prod_ext = AccWidth'(w_prod);
    assign w_off_ext  = AccWidth'(i_coeff);
    assign w_sum      = r_acc + w_off_ext;

`ifdef SATURATE_EN
    localparam logic signed [AccWidth-1:0] RES_MAX =
        {{(AccWidth-ResWidth+1){1'b0}}, {(ResWidth-1){1'b1}}};
    localparam logic signed [AccWidth-1:0] RES_MIN =
        {{(AccWidth-ResWidth+1){1'b1}}, {(ResWidth-1){1'b0}}};

    always_comb begin
        w_res = w_sum[ResWidth-1:0];
        if (w_sum > RES_MAX) begin
            w_res = RES_MAX[ResWidth-1:0];
        end else if (w_sum < RES_MIN) begin
            w_res = RES_MIN[ResWidth-1:0];
        end
    end
`else
    // Two's-complement wrap: keep only the low ResWidth bits.
    always_comb begin
        w_res = w_sum[ResWidth-1:0];
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_acc) begin
                r_acc <= r_acc + w_prod_ext;
            end
            if (i_offset) begin
                r_result <= w_res;
            end
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Sequences one neuron evaluation: optional bank load, 20 MACs, offset add, Done pulse.
// Latency: Done 23 cycles after Start acceptance with reload, 22 without.
// Start is only taken in IDLE/DONE; Start while Busy is dropped. Option: SATURATE_EN.
module neuron_mac_sequencer
    import neuron_pkg::*;
#(
    parameter int Width    = 4,
    parameter int AccWidth = 2*Width+5,
    parameter int ResWidth = 2*Width
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       Start,
    input  logic                       ReloadCoeff,
    input  logic signed [Width-1:0]    CoeffIn,
    input  logic signed [Width-1:0]    XIn,
    output logic                       EnableRegisterIn,
    output logic [SEL_W-1:0]           SEL,
    output logic                       Busy,
    output logic                       Done,
    output logic signed [ResWidth-1:0] Result
);

    state_t           r_state;
    state_t           w_next;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic             w_clr;
    logic             w_acc;
    logic             w_off;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_next;
            r_sel   <= w_sel_nxt;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_sel_nxt = r_sel;
        w_clr     = 1'b0;
        w_acc     = 1'b0;
        w_off     = 1'b0;
        case (r_state)
            // DONE accepts a new Start exactly like IDLE for back-to-back runs.
            IDLE, DONE: begin
                w_sel_nxt = '0;
                if (Start) begin
                    w_clr  = 1'b1;
                    w_next = ReloadCoeff ? LOAD : ACCUM;
                end else begin
                    w_next = IDLE;
                end
            end
            LOAD: begin
                w_sel_nxt = '0;
                w_next    = ACCUM;
            end
            ACCUM: begin
                w_acc = 1'b1;
                if (r_sel == LAST_ACC_SEL) begin
                    w_sel_nxt = OFFSET_SEL;
                    w_next    = OFFSET;
                end else begin
                    w_sel_nxt = r_sel + SEL_W'(1);
                end
            end
            OFFSET: begin
                w_off     = 1'b1;
                w_sel_nxt = '0;
                w_next    = DONE;
            end
            default: begin
                w_sel_nxt = '0;
                w_next    = IDLE;
            end
        endcase
    end

    assign SEL              = r_sel;
    assign EnableRegisterIn = (r_state == LOAD);
    assign Busy             = (r_state == LOAD) || (r_state == ACCUM) || (r_state == OFFSET);
    assign Done             = (r_state == DONE);

    neuron_mac_unit #(
        .Width    (Width),
        .AccWidth (AccWidth),
        .ResWidth (ResWidth)
    ) u_mac (
        .i_clk    (CLK),
        .i_rst_n  (reset),
        .i_clr    (w_clr),
        .i_acc    (w_acc),
        .i_offset (w_off),
        .i_coeff  (CoeffIn),
        .i_x      (XIn),
        .o_result (Result)
    );

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench for neuron_mac_sequencer with a behavioural coefficient bank and scoreboard.
// Expected results are hand-computed; SATURATE_EN selects the clamped or wrapped values.
module tb_neuron_mac_sequencer;

    logic              CLK = 1'b0;
    logic              reset = 1'b0;
    logic              Start = 1'b0;
    logic              ReloadCoeff = 1'b0;
    logic signed [3:0] CoeffIn;
    logic signed [3:0] XIn;
    logic              EnableRegisterIn;
    logic [4:0]        SEL;
    logic              Busy;
    logic              Done;
    logic signed [7:0] Result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int res;
        int cyc;
    } exp_t;
    exp_t q[$];

    logic signed [3:0] bank [0:20];
    logic signed [3:0] pend [0:20];
    logic signed [3:0] xs   [0:19];

`ifdef SATURATE_EN
    localparam int E2 = 127;
    localparam int E3 = -128;
    localparam int E6 = -128;
`else
    localparam int E2 = 7;
    localparam int E3 = -104;
    localparam int E6 = -46;
`endif

    neuron_mac_sequencer dut (
        .CLK              (CLK),
        .reset            (reset),
        .Start            (Start),
        .ReloadCoeff      (ReloadCoeff),
        .CoeffIn          (CoeffIn),
        .XIn              (XIn),
        .EnableRegisterIn (EnableRegisterIn),
        .SEL              (SEL),
        .Busy             (Busy),
        .Done             (Done),
        .Result           (Result)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Coefficient bank: registers capture on the load pulse, read is combinational on SEL.
    always @(posedge CLK) begin
        if (EnableRegisterIn) begin
            for (int i = 0; i < 21; i++) bank[i] <= pend[i];
        end
    end

    always_comb begin
        int idx;
        idx     = int'(SEL);
        CoeffIn = (idx <= 20) ? bank[idx] : 4'sd0;
        XIn     = (idx < 20) ? xs[idx] : 4'sd5;
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (Done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", int'(Result), e.res);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic set_vec(input int w, input int off, input int x);
        for (int i = 0; i < 20; i++) begin
            pend[i] = 4'(w);
            xs[i]   = 4'(x);
        end
        pend[20] = 4'(off);
    endtask

    // Issues Start now, then walks the run cycle by cycle; returns inside the DONE cycle.
    task automatic run(input bit reload, input int exp_res, input bit pulse);
        int   off;
        int   lat;
        int   errs;
        int   es;
        bit   een;
        bit   ebusy;
        exp_t e;
        off  = reload ? 1 : 0;
        lat  = 22 + off;
        errs = 0;
        Start       = 1'b1;
        ReloadCoeff = reload;
        @(posedge CLK);
        #1;
        Start       = 1'b0;
        ReloadCoeff = 1'b0;
        e.res = exp_res;
        e.cyc = cyc + lat - 1;
        q.push_back(e);
        for (int k = 1; k <= lat; k++) begin
            if (k <= off) begin
                es = 0;  een = 1'b1; ebusy = 1'b1;
            end else if (k <= off + 20) begin
                es = k - off - 1; een = 1'b0; ebusy = 1'b1;
            end else if (k == off + 21) begin
                es = 20; een = 1'b0; ebusy = 1'b1;
            end else begin
                es = 0;  een = 1'b0; ebusy = 1'b0;
            end
            if (int'(SEL) != es || EnableRegisterIn != een || Busy != ebusy) begin
                errs++;
                $display("seq step %0d: SEL=%0d en=%0b busy=%0b", k, SEL, EnableRegisterIn, Busy);
            end
            if (pulse && k == 5) Start = 1'b1;
            if (pulse && k == 6) Start = 1'b0;
            if (k < lat) begin
                @(posedge CLK);
                #1;
            end
        end
        check("sequence", errs, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bound expired");
        $fatal(1, "watchdog");
    end

    initial begin
        set_vec(0, 0, 0);
        #12;
        check("rst_sel", int'(SEL), 0);
        check("rst_outs", {EnableRegisterIn, Busy, Done}, 0);
        check("rst_result", int'(Result), 0);
        @(negedge CLK);
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_busy", Busy, 0);

        set_vec(1, 0, 1);
        run(1'b1, 20, 1'b0);
        @(negedge CLK);
        set_vec(-8, 7, -8);
        run(1'b1, E2, 1'b0);
        @(negedge CLK);
        set_vec(7, -8, -8);
        run(1'b1, E3, 1'b0);
        repeat (3) @(negedge CLK);

        // No reload: bank keeps the 7/-8 set even though new values are pending.
        set_vec(2, 3, 3);
        for (int i = 0; i < 20; i++) xs[i] = (i % 2 == 0) ? -4'sd1 : 4'sd1;
        run(1'b0, -8, 1'b1);
        // Still in the DONE cycle: chained Start with fresh samples.
        for (int i = 0; i < 20; i++) xs[i] = 4'sd3;
        run(1'b1, 123, 1'b0);
        repeat (3) @(negedge CLK);
        check("result_hold", int'(Result), 123);

        // Abort mid-accumulation with an asynchronous reset.
        set_vec(-3, -2, 5);
        Start       = 1'b1;
        ReloadCoeff = 1'b1;
        @(posedge CLK);
        #1;
        Start       = 1'b0;
        ReloadCoeff = 1'b0;
        for (int i = 0; i < 40 && SEL != 5'd10; i++) begin
            @(posedge CLK);
            #1;
        end
        check("abort_at_sel10", int'(SEL), 10);
        #2;
        reset = 1'b0;
        #1;
        check("abort_sel", int'(SEL), 0);
        check("abort_outs", {EnableRegisterIn, Busy, Done}, 0);
        check("abort_result", int'(Result), 0);
        repeat (2) @(negedge CLK);
        reset = 1'b1;
        repeat (30) @(negedge CLK);
        check("abort_idle", Busy, 0);

        run(1'b1, E6, 1'b0);
        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge CLK);
        repeat (4) @(negedge CLK);
        check("final_result_hold", int'(Result), E6);
        check("pending_done", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
